// File: rtl/common_pkg.sv
// Shared execute-stage encodings: ALU function codes plus the multiply/divide
// operation and sequencer state types.
package common;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_DIV, ALU_REM
  } alufunc_t;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam int CUT_WIDTH = 32;

  function automatic muldiv_op_t muldiv_op_of(input alufunc_t f);
    case (f)
      ALU_DIV: return MD_DIV;
      ALU_REM: return MD_REM;
      default: return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake and operand bundle.
interface muldiv_unit_if import common::*; #(parameter int XLEN = 64);
  logic            valid_in;
  muldiv_op_t      op;
  logic            is_signed;
  logic            cut;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output valid_in, op, is_signed, cut, a, b, flush,
                  input  busy, done, result);
  modport slave  (input  valid_in, op, is_signed, cut, a, b, flush,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// The *_next outputs expose the result of the step taken on the coming edge.
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dsr_reg;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    fits      = rem_shift >= {1'b0, dsr_reg};
    diff      = rem_shift[XLEN-1:0] - dsr_reg;
    rem_next  = fits ? diff : rem_shift[XLEN-1:0];
    quo_next  = {quo_reg[XLEN-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dsr_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dsr_reg <= divisor;
    end else if (step) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V MUL/DIV/REM unit (64- and 32-bit W variants).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit import common::*; #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave md
);
  localparam int CW    = $clog2(XLEN + 1);
  localparam int EXT_W = XLEN - CUT_WIDTH;

  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic w);
    return w ? {{EXT_W{x[CUT_WIDTH-1]}}, x[CUT_WIDTH-1:0]} : x;
  endfunction

  muldiv_state_t   state_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;
  logic [CW-1:0]   cnt_reg;
  muldiv_op_t      op_reg;
  logic            cut_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;

  logic            accept, signed_div, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_val, dividend_load;
  logic [XLEN-1:0] acc_next, quo_next, rem_next, q_signed, r_signed, final_val;
  logic [XLEN-1:0] fast_prod;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  assign fast_prod = fit(md.a * md.b, md.cut);
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_prod = '0;
`endif

  always_comb begin
    accept     = (state_reg == IDLE) && md.valid_in && !md.flush;
    a_ext      = md.cut ? {{EXT_W{md.is_signed & md.a[CUT_WIDTH-1]}}, md.a[CUT_WIDTH-1:0]} : md.a;
    b_ext      = md.cut ? {{EXT_W{md.is_signed & md.b[CUT_WIDTH-1]}}, md.b[CUT_WIDTH-1:0]} : md.b;
    signed_div = md.is_signed && (md.op != MD_MUL);
    a_neg      = signed_div && a_ext[XLEN-1];
    b_neg      = signed_div && b_ext[XLEN-1];
    a_mag      = a_neg ? -a_ext : a_ext;
    b_mag      = b_neg ? -b_ext : b_ext;
    min_val    = md.cut ? {{(EXT_W + 1){1'b1}}, {(CUT_WIDTH - 1){1'b0}}}
                        : {1'b1, {(XLEN - 1){1'b0}}};
    div_zero   = (b_ext == '0);
    div_ovf    = signed_div && (a_ext == min_val) && (b_ext == '1);
    special    = (md.op != MD_MUL) && (div_zero || div_ovf);
    if (md.op == MD_DIV) special_val = div_zero ? '1 : a_ext;
    else                 special_val = div_zero ? a_ext : '0;
    // W-variant magnitudes sit in the low half; pre-shift so the first step sees bit 31.
    dividend_load = md.cut ? (a_mag << EXT_W) : a_mag;

    acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    q_signed = neg_q_reg ? -quo_next : quo_next;
    r_signed = neg_r_reg ? -rem_next : rem_next;
    case (op_reg)
      MD_MUL:  final_val = fit(acc_next, cut_reg);
      MD_DIV:  final_val = fit(q_signed, cut_reg);
      default: final_val = fit(r_signed, cut_reg);
    endcase
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && !special),
    .step     ((state_reg == RUN) && (op_reg != MD_MUL)),
    .dividend (dividend_load),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      done_reg   <= 1'b0;
      result_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= MD_MUL;
      cut_reg    <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (md.flush) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (accept) begin
            op_reg     <= md.op;
            cut_reg    <= md.cut;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            mcand_reg  <= a_ext;
            mplier_reg <= b_ext;
            acc_reg    <= '0;
            cnt_reg    <= md.cut ? CW'(CUT_WIDTH) : CW'(XLEN);
            if (FAST_MUL && (md.op == MD_MUL)) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= fast_prod;
            end else if (special) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= fit(special_val, md.cut);
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          cnt_reg    <= cnt_reg - CW'(1);
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          acc_reg    <= acc_next;
          // Last step folds into the sign fix-up so DONE follows immediately.
          if (cnt_reg == CW'(1)) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            result_reg <= final_val;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy   = (state_reg == RUN) || accept;
  assign md.done   = done_reg;
  assign md.result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model checked every
// cycle, directed literal cases, then randomized traffic with flushes.
module tb_muldiv_unit;
  import common::*;

  localparam int XLEN = 64;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 65;
`endif
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) md ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .md(md));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_fn(input muldiv_op_t op, input bit sgn, input bit cut,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r   = '0;
    if (cut) begin
      case (op)
        MD_MUL: r32 = a32 * b32;
        MD_DIV: begin
          if (b32 == 0) r32 = '1;
          else if (sgn && a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
          else if (sgn) r32 = 32'($signed(a32) / $signed(b32));
          else r32 = a32 / b32;
        end
        default: begin
          if (b32 == 0) r32 = a32;
          else if (sgn && a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
          else if (sgn) r32 = 32'($signed(a32) % $signed(b32));
          else r32 = a32 % b32;
        end
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        MD_MUL: r = a * b;
        MD_DIV: begin
          if (b == 0) r = '1;
          else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else if (sgn) r = 64'($signed(a) / $signed(b));
          else r = a / b;
        end
        default: begin
          if (b == 0) r = a;
          else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else if (sgn) r = 64'($signed(a) % $signed(b));
          else r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  // Cycles from the accept cycle to the cycle in which done is high.
  function automatic int exp_latency(input muldiv_op_t op, input bit sgn, input bit cut,
                                     input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (op == MD_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return cut ? 33 : 65;
`endif
    end
    zero = cut ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (cut ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return cut ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'($urandom), 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  // Reference model: phase, absolute due cycle and the value result must show.
  longint      cyc = 0;
  longint      m_due = 0;
  int          m_phase = PH_IDLE;
  logic [63:0] m_result = '0;
  logic [63:0] m_pending = '0;
  logic        exp_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_phase  <= PH_IDLE;
      m_result <= '0;
    end else if (md.flush) begin
      m_phase <= PH_IDLE;
    end else if (m_phase == PH_DONE) begin
      m_phase <= PH_IDLE;
    end else if (m_phase == PH_RUN) begin
      if (cyc + 1 == m_due) begin
        m_phase  <= PH_DONE;
        m_result <= m_pending;
      end
    end else if (md.valid_in) begin
      if (exp_latency(md.op, md.is_signed, md.cut, md.a, md.b) == 1) begin
        m_phase  <= PH_DONE;
        m_result <= ref_fn(md.op, md.is_signed, md.cut, md.a, md.b);
      end else begin
        m_phase   <= PH_RUN;
        m_due     <= cyc + longint'(exp_latency(md.op, md.is_signed, md.cut, md.a, md.b));
        m_pending <= ref_fn(md.op, md.is_signed, md.cut, md.a, md.b);
      end
    end
  end

  always @(negedge clk) begin
    exp_busy = (m_phase == PH_RUN) || (m_phase == PH_IDLE && md.valid_in && !md.flush);
    check("busy", 64'(md.busy), 64'(exp_busy));
    check("done", 64'(md.done), 64'(m_phase == PH_DONE));
    check("result", md.result, m_result);
    if (md.done === 1'b1)
      $display("txn done: result=%h model=%h", md.result, m_result);
  end

  task automatic run_op(input string name, input muldiv_op_t op, input bit sgn, input bit cut,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int k;
    md.op = op; md.is_signed = sgn; md.cut = cut; md.a = a; md.b = b;
    md.valid_in = 1'b1;
    @(posedge clk); #1;
    md.valid_in = 1'b0;
    k = 1;
    while (md.done !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_result"}, md.result, exp_res);
    @(posedge clk); #1;
  endtask

  int pulses;
  int first;
  int k;

  initial begin
    md.valid_in = 1'b0; md.op = MD_MUL; md.is_signed = 1'b0; md.cut = 1'b0;
    md.a = '0; md.b = '0; md.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 64'(md.busy), 64'h0);
    check("reset_done", 64'(md.done), 64'h0);
    check("reset_result", md.result, 64'h0);

    run_op("mul_7x-3", MD_MUL, 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run_op("div_-20/3", MD_DIV, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_op("rem_-20%3", MD_REM, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divuw", MD_DIV, 1'b0, 1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 33);
    run_op("div_by0", MD_DIV, 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0", MD_REM, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("divw_ovf", MD_DIV, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", MD_REM, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("mul_6x7", MD_MUL, 1'b0, 1'b0, 64'd6, 64'd7, 64'd42, MUL_LAT);

    // Flush during RUN cycle 10, then a new operation the following cycle.
    md.op = MD_DIV; md.is_signed = 1'b0; md.cut = 1'b0; md.a = 64'd1000; md.b = 64'd7;
    md.valid_in = 1'b1;
    @(posedge clk); #1;
    md.valid_in = 1'b0;
    pulses = 0;
    repeat (9) begin
      if (md.done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    md.flush = 1'b1;
    @(posedge clk); #1;
    md.flush = 1'b0;
    check("flush_busy", 64'(md.busy), 64'h0);
    check("flush_done", 64'(md.done), 64'h0);
    check("flush_result", md.result, 64'd42);
    check("flush_pulses", 64'(pulses), 64'h0);
    run_op("after_flush", MD_DIV, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // valid_in held through RUN: one accept, one done.
    md.op = MD_DIV; md.is_signed = 1'b0; md.cut = 1'b1; md.a = 64'd100; md.b = 64'd7;
    md.valid_in = 1'b1;
    pulses = 0; first = 0;
    @(posedge clk); #1;
    k = 1;
    while (k < 120) begin
      if (md.done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
        md.valid_in = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_latency", 64'(first), 64'd33);
    check("hold_result", md.result, 64'd14);

    // Reset in the middle of RUN abandons the operation.
    md.op = MD_DIV; md.is_signed = 1'b1; md.cut = 1'b0; md.a = 64'd100; md.b = 64'd3;
    md.valid_in = 1'b1;
    @(posedge clk); #1;
    md.valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (80) begin
      if (md.done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check("rst_run_pulses", 64'(pulses), 64'h0);
    check("rst_run_result", md.result, 64'h0);
    check("rst_run_busy", 64'(md.busy), 64'h0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    repeat (12000) begin
      md.valid_in  = ($urandom_range(0, 1) == 1);
      md.flush     = ($urandom_range(0, 49) == 0);
      md.op        = muldiv_op_t'($urandom_range(0, 2));
      md.is_signed = ($urandom_range(0, 1) == 1);
      md.cut       = ($urandom_range(0, 1) == 1);
      md.a         = pick();
      md.b         = pick();
      @(posedge clk); #1;
    end
    md.valid_in = 1'b0;
    md.flush    = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
